load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_SIZE, default 4096, size of the data memory in bytes; legal addresses are 0 .. MEM_SIZE-1.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  CPU memory request present.
REQ-005 req_ready  output  1  request accepted on a rising edge when req_valid && req_ready.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-008 req_signed  input  1  load sign-extension enable (ignored for stores and word loads).
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-012 resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned, out-of-range or illegal-size request, valid with resp_valid.
REQ-014 mem_write_en  output  1  data memory word write strobe.
REQ-015 mem_write_addr  output  32  word-aligned byte address (bits [1:0] = 0).
REQ-016 mem_write_data  output  32  full word to write.
REQ-017 mem_read_addr  output  32  word-aligned byte address; memory returns the word on mem_read_data one cycle later (registered read).
REQ-018 mem_read_data  input  32  read word from data memory.

Function
REQ-019 States: IDLE, RD, DATA, WR, RESP; req_ready = 1 only in IDLE and RESP.
REQ-020 On acceptance, the unit latches addr, size, signed, write and wdata; mem_read_addr and mem_write_addr always equal {latched_addr[31:2],2'b00}.
REQ-021 Error check at acceptance: size 3; half with addr[0]=1; word with addr[1:0]!=0; addr >= MEM_SIZE. Any error -> RESP with resp_err=1, resp_rdata=0, no memory access.
REQ-022 Load or sub-word store: IDLE -> RD -> DATA -> RESP; the memory samples mem_read_addr at the end of RD; mem_read_data is used in DATA.
REQ-023 Word store: IDLE -> WR -> RESP; mem_write_en=1 in WR with mem_write_data = latched wdata.
REQ-024 Sub-word store in DATA: mem_write_en=1, mem_write_data = mem_read_data with the addressed lane(s) replaced (little-endian; byte lane = addr[1:0], half lane = addr[1]).
REQ-025 Load in DATA: extract the addressed lane, zero-extend or sign-extend per latched signed, and register it into resp_rdata.
REQ-026 mem_write_en is 0 in every state other than WR and DATA-with-store, and is exactly one cycle per store.
REQ-027 RESP lasts one cycle with resp_valid=1; a request presented in RESP is accepted (back-to-back), otherwise the unit goes to IDLE.
REQ-028 Latency from the acceptance edge to resp_valid high: load / sub-word store 3 cycles, word store 2, error 1.
REQ-029 Request inputs are ignored while req_ready=0; a held req_valid is not re-accepted after its own completion unless still asserted in RESP/IDLE.

Reset
REQ-030 While reset=1: state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_write_en=0 (gated combinationally), latched fields=0.
REQ-031 Reset asserted mid-operation abandons the request: no write strobe and no response for it in that cycle or after; req_ready=1 in the first cycle after reset deasserts.

Verification
REQ-032 Word store addr 0x10, data 0xDEADBEEF -> mem_write_en one cycle with addr 0x10, data 0xDEADBEEF; resp_valid 2 cycles after acceptance, err=0.
REQ-033 Memory word at 0x10 = 0xDEADBEEF; byte store addr 0x11, data 0x55 -> write 0xDEAD55EF; load byte signed at 0x13 -> resp_rdata 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-034 Halfword load signed at 0x12 of 0x8001ABCD -> 0xFFFF8001; halfword at 0x11 -> resp_err=1, rdata 0, no mem_write_en, resp 1 cycle after acceptance.
REQ-035 Word load at 0x1000 with MEM_SIZE=4096 -> resp_err=1; req_size=3 -> resp_err=1.
REQ-036 Back-to-back: word store then load at the same address presented in RESP -> load returns the stored value; no idle cycle between them.
REQ-037 Reset asserted during DATA of a byte store -> mem_write_en stays 0, memory word unchanged, no resp_valid; req_ready=1 in the first cycle after reset deasserts.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a word-wide, registered-read data memory.
// Latency is 3 cycles for loads and sub-word stores, 2 for word stores and 1 for errors; req_ready is high only in IDLE and RESP.
module load_store_unit #(
    parameter int MEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write_en,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_DATA, S_WR, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_write;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_req_err;
    logic [31:0] w_merged;
    logic [31:0] w_lane;
    logic [31:0] w_load;

    assign req_ready = !reset && (r_state == S_IDLE || r_state == S_RESP);
    assign w_accept  = req_valid && req_ready;

    assign w_req_err = (req_size == 2'd3)
                    || (req_size == 2'd1 && req_addr[0])
                    || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                    || (req_addr >= MEM_LIMIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_RESP: begin
                w_next = S_IDLE;
                if (w_accept) begin
                    if (w_req_err)                         w_next = S_RESP;
                    else if (req_write && req_size == 2'd2) w_next = S_WR;
                    else                                   w_next = S_RD;
                end
            end
            S_RD:    w_next = S_DATA;
            S_DATA:  w_next = S_RESP;
            S_WR:    w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // Read-modify-write merge: only the addressed little-endian lane(s) change.
    always_comb begin
        w_merged = mem_read_data;
        if (r_size == 2'd0)
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    always_comb begin
        w_lane = mem_read_data >> {r_addr[1:0], 3'b000};
        case (r_size)
            2'd0:    w_load = r_signed ? {{24{w_lane[7]}}, w_lane[7:0]}
                                       : {24'b0, w_lane[7:0]};
            2'd1:    w_load = r_signed ? {{16{w_lane[15]}}, w_lane[15:0]}
                                       : {16'b0, w_lane[15:0]};
            default: w_load = mem_read_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr   <= req_addr;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_write  <= req_write;
                r_wdata  <= req_wdata;
                r_err    <= w_req_err;
                r_rdata  <= '0;
            end else if (r_state == S_DATA && !r_write) begin
                r_rdata <= w_load;
            end
        end
    end

    // Gated by reset so an abandoned store can never strobe the memory.
    assign mem_write_en   = !reset && ((r_state == S_WR) || (r_state == S_DATA && r_write));
    assign mem_write_addr = {r_addr[31:2], 2'b00};
    assign mem_read_addr  = {r_addr[31:2], 2'b00};
    assign mem_write_data = (r_state == S_WR) ? r_wdata : w_merged;

    assign resp_valid = !reset && (r_state == S_RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = resp_valid ? r_rdata : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural registered-read memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write_en;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;

    load_store_unit #(.MEM_SIZE(4096)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_write_en(mem_write_en),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_write_addr[11:2]] <= mem_write_data;
        mem_read_data <= mem[mem_read_addr[11:2]];
    end

    typedef struct { logic err; logic [31:0] rdata; int lat; } exp_resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } exp_wr_t;

    exp_resp_t resp_q [$];
    exp_wr_t   wr_q   [$];
    int        acc_q  [$];
    int        cyc = 0;
    int        b2b_cnt = 0;
    int        n_vec = 0;
    int        n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            acc_q.delete();
        end else begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (resp_valid && req_valid && req_ready) b2b_cnt++;
            if (mem_write_en) begin
                if (wr_q.size() == 0) chk("unexp_wr", 32'd1, 32'd0);
                else begin
                    exp_wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_write_addr, w.addr);
                    chk("wr_data", mem_write_data, w.data);
                end
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) chk("unexp_resp", 32'd1, 32'd0);
                else begin
                    exp_resp_t r;
                    int a;
                    r = resp_q.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
                    chk("resp_err", {31'b0, resp_err}, {31'b0, r.err});
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_lat", 32'(cyc - a), 32'(r.lat));
                end
            end
        end
    end

    task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        bit done;
        done = 1'b0;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic e_err, input logic [31:0] e_rd, input int e_lat,
                         input logic e_wen, input logic [31:0] e_wa, input logic [31:0] e_wd);
        exp_resp_t r;
        exp_wr_t   w;
        r.err = e_err; r.rdata = e_rd; r.lat = e_lat;
        resp_q.push_back(r);
        if (e_wen) begin
            w.addr = e_wa; w.data = e_wd;
            wr_q.push_back(w);
        end
        drive(wr, sz, sg, a, d);
    endtask

    task automatic gap();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
        req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_wen", {31'b0, mem_write_en}, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // word store, byte RMW store, signed/unsigned byte loads
        issue(1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 0, 2, 1, 32'h10, 32'hDEADBEEF); gap();
        issue(1, 0, 0, 32'h11, 32'h00000055, 0, 0, 3, 1, 32'h10, 32'hDEAD55EF); gap();
        issue(0, 0, 1, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 3, 0, 0, 0); gap();
        issue(0, 0, 0, 32'h13, 32'h0, 0, 32'h000000DE, 3, 0, 0, 0); gap();
        issue(0, 0, 1, 32'h11, 32'h0, 0, 32'h00000055, 3, 0, 0, 0); gap();

        // halfword loads
        issue(1, 2, 0, 32'h10, 32'h8001ABCD, 0, 0, 2, 1, 32'h10, 32'h8001ABCD); gap();
        issue(0, 1, 1, 32'h12, 32'h0, 0, 32'hFFFF8001, 3, 0, 0, 0); gap();
        issue(0, 1, 0, 32'h12, 32'h0, 0, 32'h00008001, 3, 0, 0, 0); gap();
        issue(0, 1, 1, 32'h10, 32'h0, 0, 32'hFFFFABCD, 3, 0, 0, 0); gap();

        // error cases: no memory access, 1-cycle response
        issue(0, 1, 1, 32'h11, 32'h0, 1, 0, 1, 0, 0, 0); gap();
        issue(0, 2, 0, 32'h12, 32'h0, 1, 0, 1, 0, 0, 0); gap();
        issue(0, 2, 0, 32'h1000, 32'h0, 1, 0, 1, 0, 0, 0); gap();
        issue(0, 3, 0, 32'h20, 32'h0, 1, 0, 1, 0, 0, 0); gap();
        issue(1, 2, 0, 32'h1000, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0); gap();
        issue(1, 1, 0, 32'h23, 32'h1111, 1, 0, 1, 0, 0, 0); gap();
        issue(0, 2, 0, 32'hFFC, 32'h0, 0, 32'h0, 3, 0, 0, 0); gap();

        // halfword and byte RMW stores into the upper/lower lanes of 0x20
        issue(1, 1, 0, 32'h22, 32'hFFFF1234, 0, 0, 3, 1, 32'h20, 32'h12340000); gap();
        issue(1, 0, 0, 32'h20, 32'hFFFFFFAB, 0, 0, 3, 1, 32'h20, 32'h123400AB); gap();
        issue(0, 2, 0, 32'h20, 32'h0, 0, 32'h123400AB, 3, 0, 0, 0); gap();

        // back-to-back: load presented during the store's RESP cycle
        issue(1, 2, 0, 32'h40, 32'hCAFEF00D, 0, 0, 2, 1, 32'h40, 32'hCAFEF00D);
        issue(0, 2, 0, 32'h40, 32'h0, 0, 32'hCAFEF00D, 3, 0, 0, 0); gap();
        chk("b2b_count", 32'(b2b_cnt), 32'd1);

        // reset in DATA of a byte store abandons it
        drive(1, 0, 0, 32'h10, 32'h00000077);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_wen", {31'b0, mem_write_en}, 32'd0);
        chk("abort_resp", {31'b0, resp_valid}, 32'd0);
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        issue(0, 2, 0, 32'h10, 32'h0, 0, 32'h8001ABCD, 3, 0, 0, 0); gap();

        repeat (10) @(posedge clk);
        chk("resp_q_left", 32'(resp_q.size()), 32'd0);
        chk("wr_q_left", 32'(wr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
